// File: rtl/nand_cmd_pkg.sv
// Shared definitions for the NAND command path (command receiver, scheduler, op engine).
//  - command class bytes carried in cmd[31:24]
//  - engine operation codes
//  - scheduler error codes reported on err_code
//  - scheduler FSM state type
package nand_cmd_pkg;

  localparam logic [7:0] CLS_AD = 8'hAD;  // read address words
  localparam logic [7:0] CLS_AF = 8'hAF;  // program address words
  localparam logic [7:0] CLS_AE = 8'hAE;  // erase range words
  localparam logic [7:0] CLS_A0 = 8'hA0;  // program confirm

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2
  } op_code_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_OP_FAIL = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_RANGE   = 3'd3;
  localparam logic [2:0] ERR_SEQ     = 3'd4;
  localparam logic [2:0] ERR_BUSY    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/nand_op_scheduler_if.sv
// Scheduler <-> NAND op engine handshake.
//  op_valid/op_code/op_addr : request from scheduler (master)
//  op_ready                 : engine accepts request
//  op_done/op_fail          : 1-cycle completion pulse with status
interface nand_op_scheduler_if;
  import nand_cmd_pkg::*;

  logic        op_valid;
  op_code_e    op_code;
  logic [23:0] op_addr;
  logic        op_ready;
  logic        op_done;
  logic        op_fail;

  modport master (output op_valid, op_code, op_addr, input op_ready, op_done, op_fail);
  modport slave  (input op_valid, op_code, op_addr, output op_ready, op_done, op_fail);
endinterface

// File: rtl/nand_cmd_assembler.sv
// Assembles strobed command words into complete operation requests.
//  clk, rst       : clock, async active-high reset
//  cmd, start_cmd : command word and its level strobe (rising edge samples cmd)
//  blocked        : scheduler busy; words arriving now are rejected
//  req            : 1-cycle pulse, req_code/req_start/req_end valid with it
//  seq_err        : 1-cycle pulse, malformed word sequence (partial discarded)
//  rejected       : 1-cycle pulse, word arrived while blocked (ignored)
module nand_cmd_assembler
  import nand_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd,
  input  logic        start_cmd,
  input  logic        blocked,
  output logic        req,
  output op_code_e    req_code,
  output logic [23:0] req_start,
  output logic [23:0] req_end,
  output logic        seq_err,
  output logic        rejected
);

  logic        start_q, word_v;
  logic [31:0] word_q;
  logic [7:0]  cls_q;       // class of the sequence in progress
  logic [1:0]  cnt_q;       // words of that sequence seen so far; 0 = none
  logic [15:0] hi_q;        // upper address bytes of the current pair
  logic [23:0] s_q;         // erase start once its pair is complete
  logic        af_ok_q;     // a complete AF pair is held for A0
  logic [23:0] af_addr_q;

  logic [7:0]  cls_w, idx_w;
  logic [15:0] pay_w;
  logic [23:0] pair_addr;
  logic        in_prog, take, bad, step, fin_read, fin_af, fin_prog, fin_erase;

  assign cls_w     = word_q[31:24];
  assign idx_w     = word_q[23:16];
  assign pay_w     = word_q[15:0];
  assign pair_addr = {hi_q, pay_w[15:8]};
  assign in_prog   = (cnt_q != 2'd0);
  // A request still in flight to the scheduler counts as busy.
  assign take      = word_v && !(blocked || req);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    bad       = 1'b0;
    step      = 1'b0;
    fin_read  = 1'b0;
    fin_af    = 1'b0;
    fin_prog  = 1'b0;
    fin_erase = 1'b0;
    case (cls_w)
      CLS_A0: begin
        if (in_prog || idx_w != 8'd0 || !af_ok_q) bad = 1'b1;
        else                                      fin_prog = 1'b1;
      end
      CLS_AD, CLS_AF, CLS_AE: begin
        if (in_prog ? (cls_w != cls_q || idx_w != {6'd0, cnt_q}) : (idx_w != 8'd0))
          bad = 1'b1;
        else if (cls_w == CLS_AD && idx_w == 8'd1) fin_read  = 1'b1;
        else if (cls_w == CLS_AF && idx_w == 8'd1) fin_af    = 1'b1;
        else if (cls_w == CLS_AE && idx_w == 8'd3) fin_erase = 1'b1;
        else                                       step      = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the address/word holding registers are reset as well; reset must discard
  // partial commands and the AF pair, and it keeps X out of the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q   <= 1'b0;
      word_v    <= 1'b0;
      word_q    <= '0;
      cls_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      s_q       <= '0;
      af_ok_q   <= 1'b0;
      af_addr_q <= '0;
      req       <= 1'b0;
      req_code  <= OP_READ;
      req_start <= '0;
      req_end   <= '0;
      seq_err   <= 1'b0;
      rejected  <= 1'b0;
    end else begin
      start_q  <= start_cmd;
      word_v   <= start_cmd && !start_q;
      if (start_cmd && !start_q) word_q <= cmd;
      req      <= 1'b0;
      seq_err  <= 1'b0;
      rejected <= word_v && !take;
      if (take) begin
        if (bad) begin
          cnt_q   <= '0;
          seq_err <= 1'b1;
        end else if (step) begin
          cls_q <= cls_w;
          cnt_q <= cnt_q + 2'd1;
          // Even words carry addr[23:8]; odd erase words complete the start address.
          if (!idx_w[0]) hi_q <= pay_w;
          else           s_q  <= pair_addr;
          if (cls_w == CLS_AF) af_ok_q <= 1'b0;
        end else if (fin_read) begin
          cnt_q     <= '0;
          req       <= 1'b1;
          req_code  <= OP_READ;
          req_start <= pair_addr;
        end else if (fin_af) begin
          cnt_q     <= '0;
          af_ok_q   <= 1'b1;
          af_addr_q <= pair_addr;
        end else if (fin_prog) begin
          req       <= 1'b1;
          req_code  <= OP_PROGRAM;
          req_start <= af_addr_q;
        end else if (fin_erase) begin
          cnt_q     <= '0;
          req       <= 1'b1;
          req_code  <= OP_ERASE;
          req_start <= s_q;
          req_end   <= pair_addr;
        end
      end
    end
  end

endmodule

// File: rtl/nand_op_scheduler.sv
// Dispatches assembled read/program/erase commands to the NAND op engine, one op in
// flight, stepping erase ranges block by block, with a done timeout.
//  clk, rst       : clock, async active-high reset
//  cmd, start_cmd : command word and strobe from the command receiver
//  op             : engine handshake (master side)
//  busy           : dispatch until final op done/abort
//  done           : 1-cycle pulse, whole command completed OK
//  err, err_code  : sticky error and its code, cleared by the next accepted command
//  blk_cnt        : erase ops completed in the current command
module nand_op_scheduler
  import nand_cmd_pkg::*;
#(
  parameter int PAGES_PER_BLK = 64,
  parameter int TIMEOUT_CYC   = 100000,
  parameter int CW            = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                cmd,
  input  logic                       start_cmd,
  nand_op_scheduler_if.master        op,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 err_code,
  output logic [15:0]                blk_cnt
);

  localparam logic [23:0] BLK_MASK = ~24'(PAGES_PER_BLK - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  logic        req, seq_err, rejected;
  op_code_e    req_code;
  logic [23:0] req_start, req_end;

  nand_cmd_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .start_cmd (start_cmd),
    .blocked   (busy),
    .req       (req),
    .req_code  (req_code),
    .req_start (req_start),
    .req_end   (req_end),
    .seq_err   (seq_err),
    .rejected  (rejected)
  );

  state_e        state_q, state_d;
  op_code_e      code_q;
  logic [23:0]   addr_q, end_q;
  logic [CW-1:0] tcnt_q;
  logic [24:0]   next_addr;
  logic          range_bad, last_blk, expired;

  // 25-bit step so stepping past FFFFFF is seen as bit 24 rather than a wrap.
  assign next_addr = {1'b0, addr_q} + 25'(PAGES_PER_BLK);
  assign last_blk  = next_addr[24] || (next_addr[23:0] > end_q);
  assign range_bad = (req_code == OP_ERASE) && (req_end < req_start);
  assign expired   = (tcnt_q == TMO_LAST);

  assign op.op_valid = (state_q == ST_ISSUE);
  assign op.op_code  = code_q;
  assign op.op_addr  = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req && !range_bad) state_d = ST_ISSUE;
      ST_ISSUE: if (op.op_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        // op_done is tested first so it wins over a simultaneous expiry.
        if (op.op_done)
          state_d = (!op.op_fail && code_q == OP_ERASE && !last_blk) ? ST_NEXT : ST_IDLE;
        else if (expired)
          state_d = ST_IDLE;
      end
      ST_NEXT:  state_d = ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q   <= OP_READ;
      addr_q   <= '0;
      end_q    <= '0;
      tcnt_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      blk_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (rejected) begin
        err      <= 1'b1;
        err_code <= ERR_BUSY;
      end
      if (seq_err) begin
        err      <= 1'b1;
        err_code <= ERR_SEQ;
      end
      case (state_q)
        ST_IDLE: begin
          if (req && range_bad) begin
            err      <= 1'b1;
            err_code <= ERR_RANGE;
          end else if (req) begin
            code_q   <= req_code;
            addr_q   <= (req_code == OP_ERASE) ? (req_start & BLK_MASK) : req_start;
            end_q    <= req_end;
            busy     <= 1'b1;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            blk_cnt  <= '0;
          end
        end
        ST_ISSUE: tcnt_q <= '0;
        ST_WAIT: begin
          tcnt_q <= tcnt_q + CW'(1);
          if (op.op_done) begin
            if (op.op_fail) begin
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_OP_FAIL;
            end else begin
              if (code_q == OP_ERASE) blk_cnt <= blk_cnt + 16'd1;
              if (code_q == OP_ERASE && !last_blk) begin
                addr_q <= next_addr[23:0];
              end else begin
                busy <= 1'b0;
                done <= 1'b1;
              end
            end
          end else if (expired) begin
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_op_scheduler.sv
module tb_nand_op_scheduler;
  import nand_cmd_pkg::*;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd = '0;
  logic        start_cmd = 1'b0;
  logic        busy, done, err;
  logic [2:0]  err_code;
  logic [15:0] blk_cnt;

  nand_op_scheduler_if bus ();

  nand_op_scheduler #(.PAGES_PER_BLK(64), .TIMEOUT_CYC(TMO), .CW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .start_cmd (start_cmd),
    .op        (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int              n;
    logic [3:0][31:0] w;
    bit              issue;
    op_code_e        code;
    logic [23:0]     addr;
    logic [2:0]      ecode;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [31:0] w0, w1, w2, w3,
                              input bit issue, input op_code_e code,
                              input logic [23:0] addr, input logic [2:0] ecode);
    vec_t v;
    v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.issue = issue; v.code = code; v.addr = addr; v.ecode = ecode;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Strobe one word; returns two falling edges after raising the strobe.
  task automatic send_word(input logic [31:0] w);
    cmd = w;
    start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (bus.op_valid) seen = 1'b1;
    end
  endtask

  // Serve one engine operation: expect the request, accept it, complete it.
  task automatic run_op(input string tag, input op_code_e code, input logic [23:0] addr,
                        input bit fail, input bit last);
    bit seen;
    wait_valid(12, seen);
    check({tag, " op_valid seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, " op_code"}, 32'(bus.op_code), 32'(code));
    check({tag, " op_addr"}, 32'(bus.op_addr), 32'(addr));
    check({tag, " busy during op"}, 32'(busy), 32'd1);
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    check({tag, " op_valid drops after handshake"}, 32'(bus.op_valid), 32'd0);
    repeat (2) @(negedge clk);
    bus.op_done = 1'b1;
    bus.op_fail = fail;
    @(negedge clk);
    bus.op_done = 1'b0;
    bus.op_fail = 1'b0;
    check({tag, " done pulse"}, 32'(done), 32'(last && !fail));
    check({tag, " busy after op"}, 32'(busy), 32'(!last && !fail));
    if (last && !fail) begin
      @(negedge clk);
      check({tag, " done single cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[12];

  initial begin
    bit seen;
    bus.op_ready = 1'b0;
    bus.op_done  = 1'b0;
    bus.op_fail  = 1'b0;

    tbl[0]  = mk(2, 32'hAD00_0108, 32'hAD01_0400, 0, 0, 1, OP_READ, 24'h010804, ERR_NONE);
    tbl[1]  = mk(3, 32'hAF00_0108, 32'hAF01_0400, 32'hA000_0000, 0, 1, OP_PROGRAM, 24'h010804, ERR_NONE);
    tbl[2]  = mk(1, 32'hA000_0000, 0, 0, 0, 1, OP_PROGRAM, 24'h010804, ERR_NONE);
    tbl[3]  = mk(4, 32'hAE00_0001, 32'hAE01_0000, 32'hAE02_0000, 32'hAE03_8000, 0, OP_READ, 0, ERR_RANGE);
    tbl[4]  = mk(2, 32'hAE00_0000, 32'hAD00_0000, 0, 0, 0, OP_READ, 0, ERR_SEQ);
    tbl[5]  = mk(1, 32'h7700_0000, 0, 0, 0, 0, OP_READ, 0, ERR_SEQ);
    tbl[6]  = mk(1, 32'hAD01_0000, 0, 0, 0, 0, OP_READ, 0, ERR_SEQ);
    tbl[7]  = mk(2, 32'hAD00_FFFF, 32'hAD01_FF00, 0, 0, 1, OP_READ, 24'hFFFFFF, ERR_NONE);
    tbl[8]  = mk(4, 32'hAE00_0000, 32'hAE01_4500, 32'hAE02_0000, 32'hAE03_4500, 1, OP_ERASE, 24'h000040, ERR_NONE);
    tbl[9]  = mk(4, 32'hAE00_FFFF, 32'hAE01_C000, 32'hAE02_FFFF, 32'hAE03_FF00, 1, OP_ERASE, 24'hFFFFC0, ERR_NONE);
    tbl[10] = mk(2, 32'hAF00_0200, 32'hA000_0000, 0, 0, 0, OP_READ, 0, ERR_SEQ);
    tbl[11] = mk(1, 32'hA000_0000, 0, 0, 0, 0, OP_READ, 0, ERR_SEQ);

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    check("reset blk_cnt", 32'(blk_cnt), 32'd0);
    check("reset op_valid", 32'(bus.op_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 12; t++) begin
      string tag;
      tag = $sformatf("vec%0d", t);
      for (int k = 0; k < tbl[t].n; k++) send_word(tbl[t].w[k]);
      if (tbl[t].issue) begin
        run_op(tag, tbl[t].code, tbl[t].addr, 1'b0, 1'b1);
        check({tag, " err clear"}, 32'(err), 32'd0);
      end else begin
        wait_valid(6, seen);
        check({tag, " no op issued"}, 32'(seen), 32'd0);
        check({tag, " busy never"}, 32'(busy), 32'd0);
        check({tag, " err set"}, 32'(err), 32'd1);
      end
      check({tag, " err_code"}, 32'(err_code), 32'(tbl[t].ecode));
    end

    // Read latency and ready back-pressure.
    send_word(32'hAD00_0108);
    send_word(32'hAD01_0400);
    check("lat op_valid not early", 32'(bus.op_valid), 32'd0);
    @(negedge clk);
    check("lat op_valid at 2 cycles", 32'(bus.op_valid), 32'd1);
    check("lat op_addr", 32'(bus.op_addr), 32'h010804);
    @(negedge clk);
    check("lat op_valid held", 32'(bus.op_valid), 32'd1);
    check("lat op_addr held", 32'(bus.op_addr), 32'h010804);
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    check("lat op_valid dropped", 32'(bus.op_valid), 32'd0);
    repeat (6) @(negedge clk);
    bus.op_done = 1'b1;
    @(negedge clk);
    bus.op_done = 1'b0;
    check("lat done", 32'(done), 32'd1);
    check("lat busy low", 32'(busy), 32'd0);

    // Stray engine strobes while idle.
    bus.op_done = 1'b1;
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_done = 1'b0;
    bus.op_ready = 1'b0;
    @(negedge clk);
    check("idle op_done ignored", 32'(done), 32'd0);
    check("idle no op_valid", 32'(bus.op_valid), 32'd0);

    // Three-block erase.
    send_word(32'hAE00_0000); send_word(32'hAE01_4000);
    send_word(32'hAE02_0000); send_word(32'hAE03_C000);
    run_op("erase b0", OP_ERASE, 24'h000040, 1'b0, 1'b0);
    run_op("erase b1", OP_ERASE, 24'h000080, 1'b0, 1'b0);
    run_op("erase b2", OP_ERASE, 24'h0000C0, 1'b0, 1'b1);
    check("erase blk_cnt", 32'(blk_cnt), 32'd3);

    // Timeout with a rejected word while busy.
    send_word(32'hAD00_0108);
    send_word(32'hAD01_0400);
    wait_valid(12, seen);
    check("tmo op_valid seen", 32'(seen), 32'd1);
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    send_word(32'hAD00_0001);
    repeat (2) @(negedge clk);
    check("busy reject err", 32'(err), 32'd1);
    check("busy reject err_code", 32'(err_code), 32'(ERR_BUSY));
    check("busy reject op unaffected", 32'(busy), 32'd1);
    repeat (TMO - 5) @(negedge clk);
    check("tmo busy before expiry", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo busy after expiry", 32'(busy), 32'd0);
    check("tmo err_code", 32'(err_code), 32'(ERR_TIMEOUT));
    check("tmo no done", 32'(done), 32'd0);

    // Erase with a failing second block.
    send_word(32'hAE00_0000); send_word(32'hAE01_4000);
    send_word(32'hAE02_0000); send_word(32'hAE03_C000);
    run_op("fail b0", OP_ERASE, 24'h000040, 1'b0, 1'b0);
    run_op("fail b1", OP_ERASE, 24'h000080, 1'b1, 1'b0);
    check("fail err_code", 32'(err_code), 32'(ERR_OP_FAIL));
    check("fail blk_cnt", 32'(blk_cnt), 32'd1);
    wait_valid(4, seen);
    check("fail no further op", 32'(seen), 32'd0);

    // Reset mid-erase; the held AF pair must be gone afterwards.
    send_word(32'hAF00_0108); send_word(32'hAF01_0400);
    send_word(32'hAE00_0000); send_word(32'hAE01_4000);
    send_word(32'hAE02_0000); send_word(32'hAE03_C000);
    run_op("rst b0", OP_ERASE, 24'h000040, 1'b0, 1'b0);
    wait_valid(12, seen);
    check("rst b1 op_valid seen", 32'(seen), 32'd1);
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst blk_cnt", 32'(blk_cnt), 32'd0);
    check("rst op_valid", 32'(bus.op_valid), 32'd0);
    check("rst op_addr", 32'(bus.op_addr), 32'd0);
    check("rst err_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    wait_valid(10, seen);
    check("rst no op after", 32'(seen), 32'd0);
    send_word(32'hA000_0000);
    wait_valid(6, seen);
    check("rst AF pair discarded", 32'(seen), 32'd0);
    check("rst A0 err_code", 32'(err_code), 32'(ERR_SEQ));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
